// File: rtl/stream_mux.sv
// N-channel registered stream multiplexer with select or round-robin grant.
// Optional transfer counter output cnt_o when STREAM_MUX_CNT_EN is defined.
module stream_mux #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] data_i,
    input  logic [NUM_CH-1:0]       valid_i,
    output logic [NUM_CH-1:0]       ready_o,
    input  logic                    mode_i,
    input  logic [SEL_W-1:0]        sel_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [SEL_W-1:0]        ch_o
`ifdef STREAM_MUX_CNT_EN
    ,
    output logic [15:0]             cnt_o
`endif
);

    logic             load;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic [SEL_W-1:0] ptr;
    int               off;
    int               best_off;

    assign load = !valid_o || ready_i;

    // Round-robin distance of channel k from ptr is (k - ptr - 1) mod NUM_CH;
    // the valid channel with the smallest distance wins.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        off      = 0;
        best_off = NUM_CH;
        if (!mode_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (int'(sel_i) == k && valid_i[k]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(k);
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                off = (k + NUM_CH - 1 - int'(ptr)) % NUM_CH;
                if (valid_i[k] && off < best_off) begin
                    best_off = off;
                    gnt_vld  = 1'b1;
                    gnt_idx  = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        ready_o  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt_idx == SEL_W'(k)) begin
                gnt_data   = data_i[k*WIDTH +: WIDTH];
                ready_o[k] = load && gnt_vld && !reset;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            ch_o    <= '0;
            ptr     <= SEL_W'(NUM_CH - 1);
        end else if (load) begin
            if (gnt_vld) begin
                data_o  <= gnt_data;
                valid_o <= 1'b1;
                ch_o    <= gnt_idx;
                ptr     <= gnt_idx;
            end else begin
                valid_o <= 1'b0;
            end
        end
    end

`ifdef STREAM_MUX_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_o <= 16'd0;
        end else if (valid_o && ready_i) begin
            cnt_o <= cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux: directed scenarios then randomized traffic
// compared against a transaction-level reference model.
module tb_stream_mux;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] data_i;
    logic [N-1:0]   valid_i;
    logic [N-1:0]   ready_o;
    logic           mode_i;
    logic [SW-1:0]  sel_i;
    logic [W-1:0]   data_o;
    logic           valid_o;
    logic           ready_i;
    logic [SW-1:0]  ch_o;
`ifdef STREAM_MUX_CNT_EN
    logic [15:0]    cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_ch;
    int           m_ptr;
    int           m_cnt;

    logic [W-1:0]   saved_data;
    logic [N*W-1:0] d_base;
    logic [N*W-1:0] d_sel;
    logic [W-1:0]   rr_seq [5];
    logic [W-1:0]   alt_seq [4];

    stream_mux #(.WIDTH(W), .NUM_CH(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .mode_i  (mode_i),
        .sel_i   (sel_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .ch_o    (ch_o)
`ifdef STREAM_MUX_CNT_EN
        ,
        .cnt_o   (cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Grant rule straight from the channel-selection rules: select picks sel if valid,
    // round-robin walks forward from the last granted channel.
    function automatic int pick(input logic [N-1:0] v, input logic m, input int s, input int p);
        int c;
        if (!m) return (s < N && v[s]) ? s : -1;
        for (int o = 1; o <= N; o++) begin
            c = (p + o) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = N - 1;
        m_cnt   = 0;
    endtask

    // Entered just after a rising edge; applies inputs, checks ready_o, then the edge result.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic m,
                        input logic [SW-1:0] s, input logic r);
        int           g;
        logic         ld;
        logic [N-1:0] exp_rdy;
        valid_i = v;
        data_i  = d;
        mode_i  = m;
        sel_i   = s;
        ready_i = r;
        #1;
        ld      = !m_valid || r;
        g       = pick(v, m, int'(s), m_ptr);
        exp_rdy = '0;
        if (ld && g >= 0) exp_rdy[g] = 1'b1;
        check("ready_o", 32'(ready_o), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (m_valid && r) m_cnt++;
        if (ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = d[g*W +: W];
                m_ch    = g;
                m_ptr   = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        check("valid_o", 32'(valid_o), 32'(m_valid));
        check("data_o", 32'(data_o), 32'(m_data));
        check("ch_o", 32'(ch_o), 32'(m_ch));
`ifdef STREAM_MUX_CNT_EN
        check("cnt_o", 32'(cnt_o), 32'(m_cnt[15:0]));
`endif
    endtask

    initial begin
        d_base  = 32'h1312_1110;
        d_sel   = 32'h13A5_1110;
        rr_seq  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        alt_seq = '{8'h11, 8'h13, 8'h11, 8'h13};

        reset   = 1'b1;
        valid_i = 4'hF;
        data_i  = 32'hDEAD_BEEF;
        mode_i  = 1'b1;
        sel_i   = 2'd1;
        ready_i = 1'b1;
        model_reset();
        #2;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_ch", 32'(ch_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd0);
        @(posedge clk);
        #1;
        check("rst_ready_hold", 32'(ready_o), 32'd0);
        check("rst_valid_hold", 32'(valid_o), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step(4'hF, d_base, 1'b1, 2'd0, 1'b1);
            check("rr_seq", 32'(data_o), 32'(rr_seq[i]));
        end
        for (int i = 0; i < 4; i++) begin
            step(4'b1010, d_base, 1'b1, 2'd0, 1'b1);
            check("rr_alt", 32'(data_o), 32'(alt_seq[i]));
        end

        step(4'b0100, d_sel, 1'b0, 2'd2, 1'b1);
        check("sel_data", 32'(data_o), 32'hA5);
        check("sel_ch", 32'(ch_o), 32'd2);

        for (int i = 0; i < 4; i++) begin
            step(4'b0001, d_base, 1'b0, 2'd2, 1'b1);
            check("sel_miss", 32'(valid_o), 32'd0);
        end

        step(4'hF, d_base, 1'b1, 2'd0, 1'b1);
        check("bp_first_ch", 32'(ch_o), 32'd3);
        saved_data = data_o;
        for (int i = 0; i < 3; i++) begin
            step(4'hF, d_base, 1'b1, 2'd0, 1'b0);
            check("bp_stable", 32'(data_o), 32'(saved_data));
        end
        step(4'hF, d_base, 1'b1, 2'd0, 1'b1);
        check("bp_resume_ch", 32'(ch_o), 32'd0);

        step(4'hF, d_base, 1'b1, 2'd0, 1'b0);
        reset = 1'b1;
        #1;
        model_reset();
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_data", 32'(data_o), 32'd0);
        check("mid_rst_ch", 32'(ch_o), 32'd0);
        check("mid_rst_ready", 32'(ready_o), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(4'hF, d_base, 1'b1, 2'd0, 1'b1);
        check("post_rst_ch", 32'(ch_o), 32'd0);

        for (int i = 0; i < 400; i++) begin
            step(4'($urandom), 32'($urandom), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
